// File: rtl/nv_rwsp_160x514_fifo_ctrl_pkg.sv
// Shared constants and helpers for the 160x514 rwsp FIFO controller.
package nv_rwsp_160x514_fifo_ctrl_pkg;

    localparam int RAM_DEPTH = 160;
    localparam int AW        = 8;
    localparam int DW        = 514;
    localparam int OUT_DEPTH = 4;

    localparam int CNT_W = $clog2(RAM_DEPTH + 1);
    localparam int OCC_W = $clog2(OUT_DEPTH + 1);
    localparam int IDX_W = $clog2(OUT_DEPTH);
    localparam int CRD_W = OCC_W + 1;

    // RAM pointer advance with wrap at the last entry
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
        return (ptr == AW'(RAM_DEPTH - 1)) ? '0 : ptr + AW'(1);
    endfunction

endpackage

// File: rtl/nv_rwsp_outbuf.sv
// Small flop FIFO holding words already read out of the RAM.
module nv_rwsp_outbuf
    import nv_rwsp_160x514_fifo_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [DW-1:0]    din,
    input  logic             pop,
    output logic [DW-1:0]    dout,
    output logic [OCC_W-1:0] occ
);

    logic [DW-1:0]    mem [OUT_DEPTH];
    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic             do_pop;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(OUT_DEPTH - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

    assign do_pop = pop && (occ != '0);
    assign dout   = mem[head];

    // Head/tail pointers and occupancy; a simultaneous push and pop leave occ unchanged
    always_ff @(posedge clk) begin
        if (!rstn) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (push) begin
                tail <= idx_inc(tail);
            end
            if (do_pop) begin
                head <= idx_inc(head);
            end
            case ({push, do_pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Payload storage needs no reset; occupancy decides what is visible
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= din;
        end
    end

    // The read-issue credit check upstream guarantees a push always finds space
    always_ff @(posedge clk) begin
        if (rstn && push) begin
            assert (occ != OCC_W'(OUT_DEPTH));
        end
    end

endmodule

// File: rtl/nv_rwsp_160x514_fifo_ctrl.sv
// Write/read controller for the 160x514 separate-port RAM.
// Reads go through two registered RAM steps: re latches the address, ore
// registers the data, and the registered data is valid the cycle after ore.
// That cycle pushes it into the output buffer, so a word written in cycle 0
// of an empty block is presented in cycle 4.
module nv_rwsp_160x514_fifo_ctrl
    import nv_rwsp_160x514_fifo_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rstn,
    input  logic          wr_pvld,
    output logic          wr_prdy,
    input  logic [DW-1:0] wr_pd,
    output logic          rd_pvld,
    input  logic          rd_prdy,
    output logic [DW-1:0] rd_pd,
    output logic [AW-1:0] ram_wa,
    output logic          ram_we,
    output logic [DW-1:0] ram_di,
    output logic [AW-1:0] ram_ra,
    output logic          ram_re,
    output logic          ram_ore,
    input  logic [DW-1:0] ram_dout,
    output logic          fifo_empty
);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] used;
    logic [CNT_W-1:0] avail;
    logic             s1;
    logic             s2;
    logic [OCC_W-1:0] occ;
    logic [CRD_W-1:0] credit;
    logic             wr_fire;
    logic             rd_fire;

    // used holds every word still occupying a RAM slot, including the one
    // being ore-captured, so a slot cannot be rewritten before it is read.
    assign wr_prdy = (used < CNT_W'(RAM_DEPTH));
    assign wr_fire = wr_pvld && wr_prdy;

    assign ram_we = wr_fire;
    assign ram_wa = wr_ptr;
    assign ram_di = wr_pd;

    // A read is issued only if its word is guaranteed a buffer slot on arrival
    assign credit  = CRD_W'(occ) + CRD_W'(s1) + CRD_W'(s2);
    assign ram_re  = (avail != '0) && (credit < CRD_W'(OUT_DEPTH));
    assign ram_ra  = rd_ptr;
    assign ram_ore = s1;

    assign rd_pvld    = (occ != '0);
    assign rd_fire    = rd_pvld && rd_prdy;
    assign fifo_empty = (used == '0) && (occ == '0);

    // Pointers, slot/readable counters and read pipeline flags
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
            avail  <= '0;
            s1     <= 1'b0;
            s2     <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (ram_re) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            used  <= used + CNT_W'(wr_fire) - CNT_W'(s1);
            avail <= avail + CNT_W'(wr_fire) - CNT_W'(ram_re);
            s1    <= ram_re;
            s2    <= s1;
        end
    end

    // Readable words are always a subset of occupied slots
    always_ff @(posedge clk) begin
        if (rstn) begin
            assert (avail <= used);
            assert (!(ram_re && (avail == '0)));
        end
    end

    nv_rwsp_outbuf u_outbuf (
        .clk  (clk),
        .rstn (rstn),
        .push (s2),
        .din  (ram_dout),
        .pop  (rd_fire),
        .dout (rd_pd),
        .occ  (occ)
    );

endmodule

// File: tb/tb_nv_rwsp_160x514_fifo_ctrl.sv
// Self-checking bench: behavioural RAM plus a queue-based FIFO reference.
module tb_nv_rwsp_160x514_fifo_ctrl;

    localparam int TB_DEPTH = 160;
    localparam int TB_AW    = 8;
    localparam int TB_DW    = 514;
    localparam int TB_CAP   = 164;

    logic              clk;
    logic              rstn;
    logic              wr_pvld;
    logic              wr_prdy;
    logic [TB_DW-1:0]  wr_pd;
    logic              rd_pvld;
    logic              rd_prdy;
    logic [TB_DW-1:0]  rd_pd;
    logic [TB_AW-1:0]  ram_wa;
    logic              ram_we;
    logic [TB_DW-1:0]  ram_di;
    logic [TB_AW-1:0]  ram_ra;
    logic              ram_re;
    logic              ram_ore;
    logic [TB_DW-1:0]  ram_dout;
    logic              fifo_empty;

    int errors;
    int checks;

    logic [TB_DW-1:0] exp_q[$];
    logic [TB_DW-1:0] obs_q[$];
    int wr_total, re_count, ore_count;
    int we_err, wa_err, ra_err, re_err, model_err;

    nv_rwsp_160x514_fifo_ctrl dut (
        .clk        (clk),
        .rstn       (rstn),
        .wr_pvld    (wr_pvld),
        .wr_prdy    (wr_prdy),
        .wr_pd      (wr_pd),
        .rd_pvld    (rd_pvld),
        .rd_prdy    (rd_prdy),
        .rd_pd      (rd_pd),
        .ram_wa     (ram_wa),
        .ram_we     (ram_we),
        .ram_di     (ram_di),
        .ram_ra     (ram_ra),
        .ram_re     (ram_re),
        .ram_ore    (ram_ore),
        .ram_dout   (ram_dout),
        .fifo_empty (fifo_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the rwsp macro: latched read address, registered output
    logic [TB_DW-1:0] ram_mem [TB_DEPTH];
    logic [TB_AW-1:0] ram_lat;
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_wa] <= ram_di;
        if (ram_re) ram_lat <= ram_ra;
        if (ram_ore) ram_dout <= ram_mem[ram_lat];
    end

    function automatic logic [TB_DW-1:0] rand_word();
        logic [TB_DW-1:0] w;
        w = '0;
        for (int i = 0; i < 17; i++) w = {w[TB_DW-33:0], 32'($urandom)};
        return w;
    endfunction

    function automatic int order_errors();
        int n;
        n = 0;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            if (obs_q[i] !== exp_q[i]) n++;
        return n;
    endfunction

    task automatic clear_model();
        exp_q.delete();
        obs_q.delete();
        wr_total = 0; re_count = 0; ore_count = 0;
        we_err = 0; wa_err = 0; ra_err = 0; re_err = 0; model_err = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Observe one cycle: record handshakes and check FIFO-level invariants
    task automatic sample();
        int stored;
        #1;
        stored = exp_q.size() - obs_q.size();
        if (stored > TB_CAP) model_err++;
        if (stored < TB_DEPTH && wr_prdy !== 1'b1) model_err++;
        if (stored >= TB_CAP && wr_prdy !== 1'b0) model_err++;
        if (stored == 0 && rd_pvld !== 1'b0) model_err++;
        if (stored == 0 && fifo_empty !== 1'b1) model_err++;
        if (ram_we !== (wr_pvld && wr_prdy)) we_err++;
        if (ram_re === 1'b1) begin
            if (re_count >= wr_total) re_err++;
            if (ram_ra !== TB_AW'(re_count % TB_DEPTH)) ra_err++;
            re_count++;
        end
        if (wr_pvld && wr_prdy) begin
            if (ram_di !== wr_pd) we_err++;
            if (ram_wa !== TB_AW'(wr_total % TB_DEPTH)) wa_err++;
            exp_q.push_back(wr_pd);
            wr_total++;
        end
        if (ram_ore === 1'b1) ore_count++;
        if (rd_pvld && rd_prdy) obs_q.push_back(rd_pd);
    endtask

    task automatic apply_reset();
        rstn = 1'b0; wr_pvld = 1'b0; rd_prdy = 1'b0; wr_pd = '0;
        next_cycle();
        rstn = 1'b1;
        clear_model();
    endtask

    task automatic test_reset();
        rstn = 1'b0; wr_pvld = 1'b0; rd_prdy = 1'b0; wr_pd = '0;
        next_cycle();
        next_cycle();
        #1;
        checks++; if (wr_prdy !== 1'b1) begin errors++; $display("[TB] FAIL reset_wr_prdy: got %b expected 1", wr_prdy); end
        checks++; if (rd_pvld !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_pvld: got %b expected 0", rd_pvld); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_ram_we: got %b expected 0", ram_we); end
        checks++; if (ram_re !== 1'b0) begin errors++; $display("[TB] FAIL reset_ram_re: got %b expected 0", ram_re); end
        checks++; if (ram_ore !== 1'b0) begin errors++; $display("[TB] FAIL reset_ram_ore: got %b expected 0", ram_ore); end
        checks++; if (fifo_empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_fifo_empty: got %b expected 1", fifo_empty); end
        rstn = 1'b1;
        clear_model();
        next_cycle();
    endtask

    task automatic test_single_word();
        apply_reset();
        wr_pvld = 1'b1; wr_pd = TB_DW'(32'hA5); rd_prdy = 1'b1;
        sample();
        next_cycle();
        wr_pvld = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            sample();
            if (c == 1) begin
                checks++; if (ram_re !== 1'b1 || ram_ra !== 8'd0) begin errors++; $display("[TB] FAIL single_issue: got re=%b ra=%0d expected re=1 ra=0", ram_re, ram_ra); end
            end
            if (c == 2) begin
                checks++; if (ram_ore !== 1'b1) begin errors++; $display("[TB] FAIL single_ore: got %b expected 1", ram_ore); end
            end
            if (c < 4) begin
                checks++; if (rd_pvld !== 1'b0) begin errors++; $display("[TB] FAIL single_early_pvld c%0d: got %b expected 0", c, rd_pvld); end
            end
            if (c == 4) begin
                checks++; if (rd_pvld !== 1'b1 || rd_pd !== TB_DW'(32'hA5)) begin errors++; $display("[TB] FAIL single_data: got pvld=%b pd=%0h expected pvld=1 pd=a5", rd_pvld, rd_pd); end
                checks++; if (fifo_empty !== 1'b0) begin errors++; $display("[TB] FAIL single_empty_c4: got %b expected 0", fifo_empty); end
            end
            if (c == 5) begin
                checks++; if (fifo_empty !== 1'b1 || rd_pvld !== 1'b0) begin errors++; $display("[TB] FAIL single_empty_c5: got empty=%b pvld=%b expected 1/0", fifo_empty, rd_pvld); end
            end
            next_cycle();
        end
    endtask

    task automatic test_fill();
        int hs;
        bit stalled;
        apply_reset();
        hs = 0; stalled = 0;
        for (int c = 0; c < 200 && !stalled; c++) begin
            wr_pvld = 1'b1; wr_pd = TB_DW'(hs);
            sample();
            if (wr_prdy) hs++; else stalled = 1;
            next_cycle();
        end
        checks++; if (hs != TB_CAP) begin errors++; $display("[TB] FAIL fill_handshakes: got %0d expected %0d", hs, TB_CAP); end
        wr_pvld = 1'b0;
        for (int c = 0; c < 10; c++) begin
            sample();
            next_cycle();
        end
        #1;
        checks++; if (wr_prdy !== 1'b0) begin errors++; $display("[TB] FAIL fill_wr_prdy: got %b expected 0", wr_prdy); end
        checks++; if (re_count != 4) begin errors++; $display("[TB] FAIL fill_read_issues: got %0d expected 4", re_count); end
        checks++; if (rd_pvld !== 1'b1 || fifo_empty !== 1'b0) begin errors++; $display("[TB] FAIL fill_state: got pvld=%b empty=%b expected 1/0", rd_pvld, fifo_empty); end
    endtask

    task automatic test_drain();
        int first_ore, last_c, n;
        logic prdy_at_ore, prdy_after;
        first_ore = -1; last_c = 0; prdy_at_ore = 1'b1; prdy_after = 1'b0;
        rd_prdy = 1'b1; wr_pvld = 1'b0;
        for (int c = 0; c < 400 && obs_q.size() < TB_CAP; c++) begin
            sample();
            if (first_ore < 0 && ram_ore === 1'b1) begin
                first_ore = c; prdy_at_ore = wr_prdy;
            end else if (first_ore >= 0 && c == first_ore + 1) begin
                prdy_after = wr_prdy;
            end
            last_c = c;
            next_cycle();
        end
        checks++; if (obs_q.size() != TB_CAP) begin errors++; $display("[TB] FAIL drain_count: got %0d expected %0d", obs_q.size(), TB_CAP); end
        n = 0;
        for (int i = 0; i < obs_q.size(); i++) if (obs_q[i] !== TB_DW'(i)) n++;
        checks++; if (n != 0) begin errors++; $display("[TB] FAIL drain_order: got %0d misordered words expected 0", n); end
        checks++; if (prdy_at_ore !== 1'b0 || prdy_after !== 1'b1) begin errors++; $display("[TB] FAIL drain_wr_prdy: got %b then %b expected 0 then 1", prdy_at_ore, prdy_after); end
        checks++; if (last_c > 167) begin errors++; $display("[TB] FAIL drain_rate: got %0d cycles expected at most 168", last_c + 1); end
        sample();
        checks++; if (fifo_empty !== 1'b1) begin errors++; $display("[TB] FAIL drain_empty: got %b expected 1", fifo_empty); end
        checks++; if (model_err != 0 || we_err != 0 || wa_err != 0 || ra_err != 0 || re_err != 0) begin errors++; $display("[TB] FAIL fill_drain_model: got model=%0d we=%0d wa=%0d ra=%0d re=%0d expected all 0", model_err, we_err, wa_err, ra_err, re_err); end
        next_cycle();
    endtask

    task automatic test_wrap();
        int sent, first_pvld, gaps, wrap_w, wrap_r, stall_w, prev_wa, prev_ra;
        apply_reset();
        sent = 0; first_pvld = -1; gaps = 0; wrap_w = 0; wrap_r = 0; stall_w = 0;
        prev_wa = -1; prev_ra = -1;
        rd_prdy = 1'b1;
        for (int c = 0; c < 700 && obs_q.size() < 500; c++) begin
            wr_pvld = (sent < 500); wr_pd = rand_word();
            sample();
            if (wr_pvld && wr_prdy) sent++;
            if (wr_pvld && !wr_prdy) stall_w++;
            if (ram_we) begin
                if (prev_wa == TB_DEPTH - 1 && ram_wa == 8'd0) wrap_w++;
                prev_wa = int'(ram_wa);
            end
            if (ram_re) begin
                if (prev_ra == TB_DEPTH - 1 && ram_ra == 8'd0) wrap_r++;
                prev_ra = int'(ram_ra);
            end
            if (first_pvld < 0 && rd_pvld) first_pvld = c;
            else if (first_pvld >= 0 && !rd_pvld && obs_q.size() < 500) gaps++;
            next_cycle();
        end
        wr_pvld = 1'b0;
        checks++; if (obs_q.size() != 500 || order_errors() != 0) begin errors++; $display("[TB] FAIL wrap_data: got %0d words %0d misordered expected 500 and 0", obs_q.size(), order_errors()); end
        checks++; if (first_pvld != 4) begin errors++; $display("[TB] FAIL wrap_latency: got %0d expected 4", first_pvld); end
        checks++; if (gaps != 0 || stall_w != 0) begin errors++; $display("[TB] FAIL wrap_rate: got gaps=%0d stalls=%0d expected 0/0", gaps, stall_w); end
        checks++; if (wrap_w != 3 || wrap_r != 3) begin errors++; $display("[TB] FAIL wrap_pointers: got w=%0d r=%0d expected 3/3", wrap_w, wrap_r); end
        checks++; if (we_err != 0 || wa_err != 0 || ra_err != 0 || re_err != 0 || model_err != 0) begin errors++; $display("[TB] FAIL wrap_model: got we=%0d wa=%0d ra=%0d re=%0d model=%0d expected all 0", we_err, wa_err, ra_err, re_err, model_err); end
    endtask

    task automatic test_random_backpressure();
        int sent;
        apply_reset();
        sent = 0;
        for (int c = 0; c < 60000 && obs_q.size() < 10000; c++) begin
            wr_pvld = (sent < 10000) && ($urandom_range(1, 0) == 1);
            rd_prdy = ($urandom_range(1, 0) == 1);
            wr_pd = rand_word();
            sample();
            if (wr_pvld && wr_prdy) sent++;
            next_cycle();
        end
        wr_pvld = 1'b0;
        checks++; if (obs_q.size() != 10000) begin errors++; $display("[TB] FAIL random_count: got %0d expected 10000", obs_q.size()); end
        checks++; if (order_errors() != 0) begin errors++; $display("[TB] FAIL random_order: got %0d misordered expected 0", order_errors()); end
        checks++; if (re_err != 0 || ra_err != 0) begin errors++; $display("[TB] FAIL random_read_issue: got re=%0d ra=%0d expected 0/0", re_err, ra_err); end
        checks++; if (we_err != 0 || wa_err != 0 || model_err != 0) begin errors++; $display("[TB] FAIL random_model: got we=%0d wa=%0d model=%0d expected all 0", we_err, wa_err, model_err); end
        sample();
        checks++; if (fifo_empty !== 1'b1 || rd_pvld !== 1'b0) begin errors++; $display("[TB] FAIL random_final: got empty=%b pvld=%b expected 1/0", fifo_empty, rd_pvld); end
        next_cycle();
    endtask

    task automatic test_reset_mid_stream();
        int sent;
        logic [TB_DW-1:0] word;
        apply_reset();
        sent = 0;
        rd_prdy = 1'b0;
        for (int c = 0; c < 40 && sent < 20; c++) begin
            wr_pvld = 1'b1; wr_pd = rand_word();
            sample();
            if (wr_prdy) sent++;
            next_cycle();
        end
        wr_pvld = 1'b0;
        for (int c = 0; c < 4; c++) begin
            sample();
            next_cycle();
        end
        #1;
        checks++; if (rd_pvld !== 1'b1 || fifo_empty !== 1'b0) begin errors++; $display("[TB] FAIL midreset_loaded: got pvld=%b empty=%b expected 1/0", rd_pvld, fifo_empty); end
        rstn = 1'b0;
        next_cycle();
        rstn = 1'b1;
        clear_model();
        word = rand_word();
        wr_pvld = 1'b1; wr_pd = word; rd_prdy = 1'b1;
        sample();
        checks++; if (rd_pvld !== 1'b0 || wr_prdy !== 1'b1 || fifo_empty !== 1'b1) begin errors++; $display("[TB] FAIL midreset_cleared: got pvld=%b prdy=%b empty=%b expected 0/1/1", rd_pvld, wr_prdy, fifo_empty); end
        next_cycle();
        wr_pvld = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            sample();
            if (c < 4) begin
                checks++; if (rd_pvld !== 1'b0) begin errors++; $display("[TB] FAIL midreset_early c%0d: got %b expected 0", c, rd_pvld); end
            end else begin
                checks++; if (rd_pvld !== 1'b1 || rd_pd !== word) begin errors++; $display("[TB] FAIL midreset_readback: got pvld=%b pd=%0h expected 1 %0h", rd_pvld, rd_pd, word); end
            end
            next_cycle();
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        clear_model();
        rstn = 1'b0; wr_pvld = 1'b0; rd_prdy = 1'b0; wr_pd = '0;
        test_reset();
        test_single_word();
        test_fill();
        test_drain();
        test_wrap();
        test_random_backpressure();
        test_reset_mid_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
